// File: rtl/tick_counter.sv
// tick_counter: prescaled up/down counter with wrap or saturate at the bounds.
// A free-running prescaler divides the clock by DIV while en is high; every
// DIV-th enabled cycle produces a tick, and each tick steps the count toward
// the direction selected by up_dn. tc flags the tick on which the count sits
// at the bound it is heading for.
module tick_counter #(
  parameter int DIV       = 100000000,
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  // Prescaler width: at least one bit so DIV=1 still has a legal register.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = '0;
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

  // Elaboration-time guard against illegal parameter combinations.
  if (DIV < 1) begin : g_bad_div
    $error("tick_counter: DIV must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("tick_counter: WIDTH must be >= 1");
  end
  if (MAX_COUNT < 1 || (WIDTH < 32 && MAX_COUNT > ((1 << WIDTH) - 1))) begin : g_bad_max
    $error("tick_counter: MAX_COUNT must be in 1 .. 2^WIDTH-1");
  end

  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             presc_last;
  logic             at_bound;

  // Upward step: the bound is compared explicitly so the count never relies
  // on natural 2^WIDTH rollover and never exceeds MAX_COUNT.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    if (c >= CNT_MAX) begin
      r = SATURATE ? CNT_MAX : CNT_ZERO;
    end else begin
      r = c + CNT_ONE;
    end
    return r;
  endfunction

  // Downward step: zero is the lower bound; wrap lands on MAX_COUNT, not 2^WIDTH-1.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    if (c == CNT_ZERO) begin
      r = SATURATE ? CNT_ZERO : CNT_MAX;
    end else if (c > CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = c - CNT_ONE;
    end
    return r;
  endfunction

  // Loaded values above the upper bound are clamped so count stays in range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // With DIV=1 every enabled cycle is a tick, independent of the prescaler.
  assign presc_last = (DIV == 1) ? 1'b1 : (presc == PRESC_LAST);

  // The direction-dependent bound the count is currently heading toward.
  assign at_bound = up_dn ? (count == CNT_MAX) : (count == CNT_ZERO);

  // Strobes are purely combinational; clr/load do not mask them.
  always_comb begin
    tick = en & presc_last;
    tc   = tick & at_bound;
  end

  // Prescaler next state: clear/load restart the period, en advances it.
  always_comb begin
    presc_nxt = presc;
    if (clr || load) begin
      presc_nxt = PRESC_ZERO;
    end else if (en) begin
      if (presc_last) begin
        presc_nxt = PRESC_ZERO;
      end else begin
        presc_nxt = presc + PRESC_ONE;
      end
    end
  end

  // Count next state: clr beats load, load beats (and discards) the tick step.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = CNT_ZERO;
    end else if (load) begin
      count_nxt = clamp_load(load_val);
    end else if (tick) begin
      count_nxt = up_dn ? step_up(count) : step_dn(count);
    end
  end

  // State registers; reset overrides every other control and discards any partial period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= PRESC_ZERO;
      count <= CNT_ZERO;
    end else begin
      presc <= presc_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// Bench for tick_counter: three instances share one stimulus stream
//   A: DIV=4, MAX=9, wrap      B: DIV=4, MAX=9, saturate      C: DIV=1, MAX=9, wrap
// The stimulus process pushes expected outputs into a scoreboard queue; a
// monitor process pops and compares them on the falling edge.
module tb_tick_counter;

  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tick_a, tick_b, tick_c;
  logic       tc_a, tc_b, tc_c;

  always #5 clk = ~clk;

  tick_counter #(.DIV(4), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_a), .tick(tick_a), .tc(tc_a));

  tick_counter #(.DIV(4), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_b), .tick(tick_b), .tc(tc_b));

  tick_counter #(.DIV(1), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_c), .tick(tick_c), .tc(tc_c));

  typedef struct {
    int    id;
    int    cnt;
    bit    tk;
    bit    tcv;
    bit    hand;
    string name;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  int divs[3] = '{4, 4, 1};
  bit sats[3] = '{1'b0, 1'b1, 1'b0};
  int m_presc[3];
  int m_cnt[3];
  string cur_name = "reset";

  // Monitor: compare everything expected for this cycle against the DUTs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   ac;
      bit   at, atc;
      e = sb.pop_front();
      case (e.id)
        0:       begin ac = int'(cnt_a); at = tick_a; atc = tc_a; end
        1:       begin ac = int'(cnt_b); at = tick_b; atc = tc_b; end
        default: begin ac = int'(cnt_c); at = tick_c; atc = tc_c; end
      endcase
      checks++;
      if (e.hand) begin
        if (ac != e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d: count=%0d expected=%0d", e.name, e.id, ac, e.cnt);
        end
      end else if (ac != e.cnt || at != e.tk || atc != e.tcv) begin
        failures++;
        $display("FAIL %s dut%0d @%0t: count/tick/tc=%0d/%0b/%0b expected=%0d/%0b/%0b",
                 e.name, e.id, $time, ac, at, atc, e.cnt, e.tk, e.tcv);
      end
    end
  end

  // Hand-computed count expectation for the next observed cycle.
  task automatic hand(input int id, input int v, input string nm);
    exp_t e;
    e.id = id; e.cnt = v; e.tk = 1'b0; e.tcv = 1'b0; e.hand = 1'b1; e.name = nm;
    sb.push_back(e);
  endtask

  // One clock: push the model's expected outputs, advance the model, then
  // wait until just after the next rising edge.
  task automatic step();
    exp_t e;
    bit   tk, tcv;
    for (int i = 0; i < 3; i++) begin
      tk  = en && (m_presc[i] == divs[i] - 1);
      tcv = tk && ((up_dn && m_cnt[i] == MAXC) || (!up_dn && m_cnt[i] == 0));
      e.id = i; e.cnt = m_cnt[i]; e.tk = tk; e.tcv = tcv; e.hand = 1'b0; e.name = cur_name;
      sb.push_back(e);
      if (rst || clr) begin
        m_presc[i] = 0;
        m_cnt[i]   = 0;
      end else if (load) begin
        m_presc[i] = 0;
        m_cnt[i]   = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
      end else begin
        if (en) m_presc[i] = (m_presc[i] + 1) % divs[i];
        if (tk) begin
          if (up_dn)
            m_cnt[i] = sats[i] ? ((m_cnt[i] == MAXC) ? MAXC : m_cnt[i] + 1)
                               : (m_cnt[i] + 1) % (MAXC + 1);
          else
            m_cnt[i] = sats[i] ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                               : (m_cnt[i] + MAXC) % (MAXC + 1);
        end
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Initial reset: state is unknown until the first reset edge.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin m_presc[i] = 0; m_cnt[i] = 0; end
    cur_name = "reset";
    load = 1'b1; load_val = 4'd6; en = 1'b1;
    step();                                // rst overrides load and en
    hand(0, 0, "reset_cnt_a"); hand(1, 0, "reset_cnt_b");
    en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0;

    // Wrap up from reset: ten ticks on A bring it back to 0; B holds at 9.
    cur_name = "wrap_up";
    en = 1'b1; up_dn = 1'b1;
    run(40);
    hand(0, 0, "wrap_up_a40"); hand(1, 9, "wrap_up_b40"); hand(2, 0, "wrap_up_c40");
    run(4);

    // Wrap down from 0: A goes 9 (tc), 8, 7.
    cur_name = "wrap_down";
    clr = 1'b1; step(); clr = 1'b0;
    up_dn = 1'b0;
    run(12);
    hand(0, 7, "wrap_dn_a"); hand(1, 0, "wrap_dn_b"); hand(2, 8, "wrap_dn_c");
    run(1);

    // Load 7, count up: B saturates at 9 and tc repeats every 4 cycles.
    cur_name = "saturate";
    load = 1'b1; load_val = 4'd7; up_dn = 1'b1; step(); load = 1'b0;
    hand(0, 7, "load7_a"); hand(1, 7, "load7_b");
    run(16);
    hand(0, 1, "sat_a"); hand(1, 9, "sat_b"); hand(2, 3, "sat_c");
    run(3);

    // clr and load together on a tick cycle: clr wins.
    cur_name = "prio_clr_load";
    clr = 1'b1; load = 1'b1; load_val = 4'd5; step();
    clr = 1'b0; load = 1'b0;
    hand(0, 0, "prio_clr_a"); hand(1, 0, "prio_clr_b"); hand(2, 0, "prio_clr_c");
    run(3);
    // Load above MAX on a tick cycle clamps to 9 and discards the step.
    cur_name = "load_clamp";
    load = 1'b1; load_val = 4'd12; step(); load = 1'b0;
    hand(0, 9, "clamp_a"); hand(1, 9, "clamp_b"); hand(2, 9, "clamp_c");

    // Enable gating at presc=2: nothing moves for 10 cycles.
    cur_name = "en_gate";
    run(2);
    en = 1'b0;
    run(10);
    hand(0, 9, "gate_hold_a"); hand(1, 9, "gate_hold_b");
    en = 1'b1;
    run(3);                               // tick on the second cycle after restore

    // Direction change takes effect on the very next tick.
    cur_name = "dir_change";
    for (int k = 0; k < 12; k++) begin
      up_dn = (k % 3) != 0;
      step();
    end

    // Reset mid-period with count=5, presc=3, en and load high.
    cur_name = "mid_reset";
    load = 1'b1; load_val = 4'd5; step(); load = 1'b0;
    up_dn = 1'b1;
    run(3);
    rst = 1'b1; load = 1'b1; load_val = 4'd8; step();
    rst = 1'b0; load = 1'b0;
    hand(0, 0, "mid_rst_a"); hand(1, 0, "mid_rst_b"); hand(2, 0, "mid_rst_c");
    run(5);                               // first tick on A exactly 4 cycles after release

    // DIV=1 instance: tick follows en every cycle.
    cur_name = "div1_en";
    for (int k = 0; k < 8; k++) begin
      en = (k % 2) == 0;
      step();
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
